// File: rtl/fixed_point_sign_restore_pkg.sv
// Shared types and helpers for fixed_point_sign_restore.
// Holds MIN/MAX constants, the sign tag and the negate helper.
package fixed_point_pkg;

  typedef struct packed {
    logic sign;
    logic ovf;
  } sign_tag_t;

  localparam int TAG_W = $bits(sign_tag_t);

  function automatic logic [31:0] min_of(input int unsigned w);
    return 32'd1 << (w - 32'd1);
  endfunction

  function automatic logic [31:0] max_of(input int unsigned w);
    return min_of(w) - 32'd1;
  endfunction

  // {ovf, -v} within w bits; ovf marks v == MIN (negation wraps)
  function automatic logic [32:0] neg_ovf(
    input logic [31:0] v,
    input int unsigned w
  );
    logic [31:0] mask;
    logic [31:0] n;
    mask = min_of(w) | max_of(w);
    n = (~v + 32'd1) & mask;
    return {((v & mask) == min_of(w)), n};
  endfunction

endpackage

// File: rtl/fixed_point_sign_restore_if.sv
// Request, ALU and result signals of fixed_point_sign_restore.
// slave is the block's view, master the surrounding logic's view.
interface fixed_point_sign_restore_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] VALUE_IN;
  logic             VALID_IN;
  logic             READY_IN;
  logic [WIDTH-1:0] ALU_VALUE_OUT;
  logic             ALU_VALID_OUT;
  logic [WIDTH-1:0] ALU_VALUE_IN;
  logic             ALU_VALID_IN;
  logic [WIDTH-1:0] VALUE_OUT;
  logic             VALID_OUT;
  logic             OVERFLOW;

  modport slave (
    input  VALUE_IN, VALID_IN,
    input  ALU_VALUE_IN, ALU_VALID_IN,
    output READY_IN,
    output ALU_VALUE_OUT, ALU_VALID_OUT,
    output VALUE_OUT, VALID_OUT, OVERFLOW
  );

  modport master (
    output VALUE_IN, VALID_IN,
    output ALU_VALUE_IN, ALU_VALID_IN,
    input  READY_IN,
    input  ALU_VALUE_OUT, ALU_VALID_OUT,
    input  VALUE_OUT, VALID_OUT, OVERFLOW
  );
endinterface

// File: rtl/sign_tag_fifo.sv
// In-order FIFO of sign tags for outstanding ALU operations.
// DEPTH must be a power of two so the pointers wrap naturally.
module sign_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [TAG_W-1:0]         din,
  output logic [TAG_W-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [TAG_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (cnt_q == CW'(DEPTH));
    empty   = (cnt_q == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    dout  = mem_q[rd_q];
    count = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/fixed_point_sign_restore.sv
// Strips sign before a shared odd-symmetric ALU, restores it after.
// FIXED_POINT_SIGN_RESTORE_SATURATE_EN: -MIN on result side gives MAX.
module fixed_point_sign_restore
  import fixed_point_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FRAC_BITS = 3,
  parameter int DEPTH     = 4
) (
  input  logic CLK,
  input  logic RST,
  fixed_point_sign_restore_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(max_of(WIDTH));
  localparam int CW = $clog2(DEPTH) + 1;

  logic             push, pop, full, empty;
  logic [CW-1:0]    count;
  sign_tag_t        tag_in, tag_out;
  logic [32:0]      req_n, res_n;
  logic [WIDTH-1:0] mag;
  logic             unused_ok;

  logic             alu_valid_q, alu_valid_d;
  logic [WIDTH-1:0] alu_value_q, alu_value_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             ovf_q, ovf_d;

  sign_tag_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .din   (tag_in),
    .dout  (tag_out),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    push  = bus.VALID_IN && !full;
    pop   = bus.ALU_VALID_IN && !empty;
    req_n = neg_ovf(32'(bus.VALUE_IN), WIDTH);
    res_n = neg_ovf(32'(bus.ALU_VALUE_IN), WIDTH);

    tag_in.sign = bus.VALUE_IN[WIDTH-1];
    tag_in.ovf  = tag_in.sign && req_n[32];
    mag = bus.VALUE_IN;
    if (tag_in.ovf) begin
      mag = MAX_V;
    end else if (tag_in.sign) begin
      mag = req_n[WIDTH-1:0];
    end

    alu_valid_d = push;
    alu_value_d = push ? mag : alu_value_q;

    valid_d = pop;
    value_d = value_q;
    ovf_d   = ovf_q;
    if (pop) begin
      value_d = bus.ALU_VALUE_IN;
      ovf_d   = tag_out.ovf;
      if (tag_out.sign) begin
        value_d = res_n[WIDTH-1:0];
        ovf_d   = tag_out.ovf | res_n[32];
`ifdef FIXED_POINT_SIGN_RESTORE_SATURATE_EN
        if (res_n[32]) value_d = MAX_V;
`endif
      end
    end

    unused_ok = ^{req_n[31:WIDTH], res_n[31:WIDTH],
                  count, 1'(FRAC_BITS)};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      alu_valid_q <= 1'b0;
      alu_value_q <= '0;
      valid_q     <= 1'b0;
      value_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      alu_valid_q <= alu_valid_d;
      alu_value_q <= alu_value_d;
      valid_q     <= valid_d;
      value_q     <= value_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.READY_IN      = !full;
  assign bus.ALU_VALID_OUT = alu_valid_q;
  assign bus.ALU_VALUE_OUT = alu_value_q;
  assign bus.VALID_OUT     = valid_q;
  assign bus.VALUE_OUT     = value_q;
  assign bus.OVERFLOW      = ovf_q;
endmodule
